// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and store-lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size lives in funct3[1:0]; loads and stores share the lane pattern.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = rdata;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory stage: req/gnt/rvalid handshake, store lane steering,
// load extension, core stall and transaction timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] Alu_out,
    input  logic [31:0] rdata2,
    output logic [31:0] load,
    output logic        stall,
    output logic        addr_fault,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      load_q, load_d;
    logic [3:0]       be_q, be_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic             we_q, we_d;
    logic             bus_err_q, bus_err_d;

    logic             mem_op, bad_op, accept, timed_out, capture, abort;
    logic [31:0]      ext_data;

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    // Illegal encodings and misalignment are rejected before any bus access.
    always_comb begin
        bad_op = 1'b0;
        case (funct3)
            F3_B:    bad_op = 1'b0;
            F3_BU:   bad_op = mem_write;
            F3_H:    bad_op = Alu_out[0];
            F3_HU:   bad_op = mem_write | Alu_out[0];
            F3_W:    bad_op = |Alu_out[1:0];
            default: bad_op = 1'b1;
        endcase
    end

    assign mem_op     = mem_read | mem_write;
    assign addr_fault = mem_op & bad_op;
    assign accept     = (state_q == IDLE) & mem_op & ~bad_op;
    assign timed_out  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completing handshake wins over a timeout expiring in the same cycle.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (dmem_gnt && (we_q || dmem_rvalid)) begin
                    state_d = DONE;
                    capture = ~we_q;
                end else if (timed_out) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end else if (dmem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else if (timed_out) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        dmem_req = 1'b0;
        case (state_q)
            IDLE: stall = accept;
            REQ: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
            end
            WAIT:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        f3_d      = f3_q;
        off_d     = off_q;
        we_d      = we_q;
        load_d    = load_q;
        bus_err_d = abort;
        if (accept) begin
            addr_d  = {Alu_out[31:2], 2'b00};
            off_d   = Alu_out[1:0];
            f3_d    = funct3;
            we_d    = mem_write;
            be_d    = lane_be(funct3, Alu_out[1:0]);
            wdata_d = lane_wdata(funct3, rdata2);
        end
        if (capture) begin
            load_d = ext_data;
        end else if (abort) begin
            load_d = '0;
        end
        if ((state_q == REQ || state_q == WAIT) && (state_d == REQ || state_d == WAIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            we_q      <= 1'b0;
            load_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            we_q      <= we_d;
            load_q    <= load_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign load       = load_q;
    assign bus_err    = bus_err_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues ops and queues expected
// bus beats and core responses; a monitor pops and compares them as they appear.
module tb_load_store_unit;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] Alu_out, rdata2;
    logic [31:0] load;
    logic        stall, addr_fault, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .Alu_out    (Alu_out),
        .rdata2     (rdata2),
        .load       (load),
        .stall      (stall),
        .addr_fault (addr_fault),
        .bus_err    (bus_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        fault;
        logic        err;
        logic [31:0] load;
        int          stalls;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];

    int total = 0;
    int bad   = 0;

    // Memory behaviour for the current transaction (written by the driver only).
    int          g_gnt_dly = 0;
    int          g_rv_dly  = 0;
    logic [31:0] g_rdata   = '0;
    bit          g_no_gnt  = 0;

    logic [31:0] model_load = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int msize(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit mfault(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1;
        if (wr && f3 >= 3'd4) return 1;
        return (int'(a[1:0]) % msize(f3)) != 0;
    endfunction

    function automatic logic [3:0] mbe(input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = ((1 << msize(f3)) - 1) << a[1:0];
        return v[3:0];
    endfunction

    function automatic logic [31:0] mwdata(input logic [2:0] f3, input logic [31:0] d);
        logic [63:0] unit, w;
        int sz;
        sz   = msize(f3);
        unit = {32'd0, d} & ((64'd1 << (8 * sz)) - 64'd1);
        w    = '0;
        for (int i = 0; i < 4 / sz; i++) w = w | (unit << (8 * sz * i));
        return w[31:0];
    endfunction

    function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [63:0] mask, v;
        int sz;
        sz   = msize(f3);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = ({32'd0, rd} >> (8 * int'(a[1:0]))) & mask;
        if (f3[2] == 1'b0 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- memory responder ----------------
    int gcnt = 0, rcnt = 0;
    bit pend = 0, prev_req = 0;

    initial begin
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (dmem_req) begin
                if (!prev_req) gcnt = g_gnt_dly;
                if (!g_no_gnt) begin
                    if (gcnt == 0) begin
                        dmem_gnt = 1'b1;
                        if (!dmem_we) begin
                            if (g_rv_dly == 0) begin
                                dmem_rvalid = 1'b1;
                                dmem_rdata  = g_rdata;
                            end else begin
                                pend = 1;
                                rcnt = g_rv_dly - 1;
                            end
                        end
                    end else begin
                        gcnt--;
                    end
                end
            end else if (pend) begin
                if (rcnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = g_rdata;
                    pend        = 0;
                end else begin
                    rcnt--;
                end
            end
            prev_req = dmem_req;
        end
    end

    // ---------------- monitor ----------------
    int stall_cnt = 0;

    initial begin
        bus_t  b;
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_cnt = 0;
            end else begin
                if (dmem_req && dmem_gnt) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_bus_beat", dmem_addr, 32'hxxxx_xxxx);
                    end else begin
                        b = bus_q.pop_front();
                        chk("dmem_addr", dmem_addr, b.addr);
                        chk("dmem_we", {31'd0, dmem_we}, {31'd0, b.we});
                        chk("dmem_be", {28'd0, dmem_be}, {28'd0, b.be});
                        if (b.we) chk("dmem_wdata", dmem_wdata, b.wdata);
                    end
                end
                if ((mem_read || mem_write) && !stall) begin
                    if (resp_q.size() == 0) begin
                        chk("unexpected_response", load, 32'hxxxx_xxxx);
                    end else begin
                        r = resp_q.pop_front();
                        chk("addr_fault", {31'd0, addr_fault}, {31'd0, r.fault});
                        chk("bus_err", {31'd0, bus_err}, {31'd0, r.err});
                        chk("load", load, r.load);
                        chk("stall_cycles", stall_cnt, r.stalls);
                    end
                    stall_cnt = 0;
                end else begin
                    chk("bus_err_idle", {31'd0, bus_err}, 32'd0);
                    if (stall) stall_cnt++;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_op(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        Alu_out   = a;
        rdata2    = d;
    endtask

    task automatic clear_op();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int gd, input int rvd, input logic [31:0] rdat, input bit nog);
        bus_t  b;
        resp_t r;
        int    busy;
        bit    done;
        g_gnt_dly = gd;
        g_rv_dly  = rvd;
        g_rdata   = rdat;
        g_no_gnt  = nog;
        r.fault   = mfault(wr, f3, a);
        r.err     = 1'b0;
        r.stalls  = 0;
        if (!r.fault) begin
            busy = nog ? TMO + 1 : (wr ? gd + 1 : gd + 1 + rvd);
            if (!nog && gd < TMO) begin
                b.addr  = {a[31:2], 2'b00};
                b.we    = wr;
                b.be    = mbe(f3, a);
                b.wdata = mwdata(f3, d);
                bus_q.push_back(b);
            end
            if (busy > TMO) begin
                r.err      = 1'b1;
                r.stalls   = TMO + 1;
                model_load = '0;
            end else begin
                r.stalls = busy + 1;
                if (rd) model_load = mload(f3, a, rdat);
            end
        end
        r.load = model_load;
        resp_q.push_back(r);
        drive_op(rd, wr, f3, a, d);
        done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL op_completion actual=stalled required=released t=%0t", $time);
        end
        @(posedge clk);
        #1;
        clear_op();
    endtask

    initial begin
        bit          rd;
        logic [2:0]  f3;
        bus_t        b;
        rst_n = 1'b0;
        clear_op();
        funct3  = '0;
        Alu_out = '0;
        rdata2  = '0;
        #2;
        chk("rst_load", load, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue(1, 0, 3'b010, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF, 0);
        issue(1, 0, 3'b000, 32'h103, 32'h0, 1, 1, 32'h80000000, 0);
        issue(1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80000000, 0);
        issue(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 2, 0, 32'h0, 0);
        issue(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 0);
        issue(0, 1, 3'b100, 32'h100, 32'h55, 0, 0, 32'h0, 0);
        issue(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 0);
        issue(1, 0, 3'b001, 32'h202, 32'h0, 0, 1, 32'h8001_7FFF, 0);
        issue(1, 0, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0, 1);
        issue(1, 0, 3'b101, 32'h302, 32'h0, 0, 0, 32'hF00D_1234, 0);
        issue(1, 0, 3'b010, 32'h400, 32'h0, 2, 100, 32'hAAAA_5555, 0);
        repeat (60) @(posedge clk);
        #1;
        chk("late_rvalid_after_timeout", load, 32'd0);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            rd = ($urandom_range(0, 1) == 1);
            f3 = 3'($urandom_range(0, 7));
            issue(rd, !rd, f3, $urandom & 32'h0000_0FFF, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Reset while a request is waiting for grant
        g_no_gnt = 1;
        drive_op(1, 0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("req_before_reset", {31'd0, dmem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        clear_op();
        #1;
        chk("req_drops_async", {31'd0, dmem_req}, 32'd0);
        chk("load_after_reset", load, 32'd0);
        model_load = '0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while waiting for read data; the late rvalid must be ignored
        issue(1, 0, 3'b010, 32'h600, 32'h0, 0, 1, 32'h1234_5678, 0);
        g_no_gnt  = 0;
        g_gnt_dly = 0;
        g_rv_dly  = 10;
        g_rdata   = 32'hCAFE_F00D;
        b.addr = 32'h700; b.we = 1'b0; b.be = 4'b1111; b.wdata = '0;
        bus_q.push_back(b);
        drive_op(1, 0, 3'b010, 32'h700, 32'h0);
        repeat (3) @(negedge clk);
        chk("stall_in_wait", {31'd0, stall}, 32'd1);
        #2;
        rst_n = 1'b0;
        clear_op();
        #1;
        chk("req_low_reset_in_wait", {31'd0, dmem_req}, 32'd0);
        chk("load_cleared_by_reset", load, 32'd0);
        model_load = '0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("late_rvalid_after_reset", load, 32'd0);
        issue(1, 0, 3'b000, 32'h801, 32'h0, 1, 2, 32'h0000_7F00, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("bus_queue_drained", bus_q.size(), 32'd0);
        chk("resp_queue_drained", resp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
